// File: rtl/uart_tx_rs485.sv
// uart_tx_rs485: 8N1/8N2 UART transmitter with RS485 driver-enable lead/tail sequencing
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, latched on handshake
//   tx_valid  tx_data is valid
//   tx_ready  block can accept a byte this cycle (IDLE or DE_TAIL)
//   uart_txd  serial output, idle high, LSB first
//   en_rs485  RS485 driver enable, high = drive bus
//   tx_done   one-cycle pulse when the last stop bit ends
//   tx_busy   high in every state except IDLE
module uart_tx_rs485 #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int UART_BPS       = 115200,
  parameter int STOP_BITS      = 1,
  parameter int DE_LEAD_CYCLES = 16,
  parameter int DE_TAIL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       en_rs485,
  output logic       tx_done,
  output logic       tx_busy
);
  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int BW = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;
  localparam int DE_MAX = (DE_LEAD_CYCLES > DE_TAIL_CYCLES) ? DE_LEAD_CYCLES : DE_TAIL_CYCLES;
  localparam int DW = (DE_MAX > 2) ? $clog2(DE_MAX) : 1;
  if ((STOP_BITS != 1 && STOP_BITS != 2) || BAUD_CNT < 2) begin : g_bad_param
    $error("uart_tx_rs485: STOP_BITS must be 1 or 2 and CLK_FREQ/UART_BPS must be >= 2");
  end
  typedef enum logic [2:0] {IDLE, DE_LEAD, START, DATA, STOP, DE_TAIL} state_t;
  state_t state;
  logic [BW-1:0] baud_cnt;
  logic [DW-1:0] de_cnt;
  logic [2:0] bit_idx;
  logic stop_idx;
  logic [7:0] shift_reg;
  logic handshake;
  logic baud_end;
  assign tx_ready = (state == IDLE) || (state == DE_TAIL);
  assign tx_busy = state != IDLE;
  assign handshake = tx_valid && tx_ready;
  assign baud_end = baud_cnt == BW'(BAUD_CNT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      uart_txd <= 1'b1;
      en_rs485 <= 1'b0;
      tx_done <= 1'b0;
      baud_cnt <= '0;
      de_cnt <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      shift_reg <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            shift_reg <= tx_data;
            en_rs485 <= 1'b1;
            de_cnt <= '0;
            if (DE_LEAD_CYCLES == 0) begin
              state <= START;
              uart_txd <= 1'b0;
            end else begin
              state <= DE_LEAD;
            end
          end
        end
        DE_LEAD: begin
          if (de_cnt == DW'(DE_LEAD_CYCLES - 1)) begin
            state <= START;
            uart_txd <= 1'b0;
            de_cnt <= '0;
          end else begin
            de_cnt <= de_cnt + 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state <= DATA;
            bit_idx <= '0;
            uart_txd <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              stop_idx <= 1'b0;
              uart_txd <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_txd <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              tx_done <= 1'b1;
              de_cnt <= '0;
              if (DE_TAIL_CYCLES == 0) begin
                state <= IDLE;
                en_rs485 <= 1'b0;
              end else begin
                state <= DE_TAIL;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DE_TAIL: begin
          // A new byte here (even on the expiry cycle) goes straight to START, so the bus is never released
          if (handshake) begin
            shift_reg <= tx_data;
            state <= START;
            uart_txd <= 1'b0;
            de_cnt <= '0;
          end else if (de_cnt == DW'(DE_TAIL_CYCLES - 1)) begin
            state <= IDLE;
            en_rs485 <= 1'b0;
            de_cnt <= '0;
          end else begin
            de_cnt <= de_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
